param_data_mem: RTL and testbench

Parametrised data memory, the next generation of the datapath's word-addressed data RAM. It is generalised in data width, depth and response latency. It accepts one request at a time through a valid/ready handshake and returns every read or write as a response pulse. It sits between the load/store stage and the register write-back mux, and flags misaligned or out-of-range accesses instead of silently aliasing them.

---
 rtl/dmem_pkg.sv | 22 ++
 rtl/dmem_array.sv | 44 ++++
 rtl/param_data_mem.sv | 154 +++++++++++++++
 tb/tb_param_data_mem.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the parametrised data memory.
package dmem_pkg;

  // Supported response latency range, in cycles from the accept edge
  localparam int unsigned RdLatMin = 1;
  localparam int unsigned RdLatMax = 8;

  // Width of the wait counter; holds RdLatMax-2 at most
  localparam int unsigned CntW = 3;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } dmem_state_e;

  // Number of byte-offset bits below the word index
  function automatic int unsigned lsb_bits(input int unsigned data_w);
    return (data_w <= 8) ? 0 : $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage for the data memory: reset initialisation and lane-masked write.
// Read is combinational; the owner registers the word on the accept edge.
module dmem_array #(
  parameter int unsigned       DATA_W     = 16,
  parameter int unsigned       DEPTH      = 30,
  parameter logic [DATA_W-1:0] INIT_WORD0 = 16'hABCD,
  localparam int unsigned      AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned      NB         = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [NB-1:0]     be,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Storage: word 0 reloads INIT_WORD0 on reset, every enabled lane commits on a write
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= (i == 0) ? INIT_WORD0 : '0;
      end
    end else if (we) begin
      for (int b = 0; b < NB; b++) begin
        if (be[b]) begin
          mem_q[addr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
  end

  // Read port; indices past the last word read as zero instead of aliasing
  always_comb begin
    rdata = '0;
    if ({1'b0, addr} < (AW + 1)'(DEPTH)) begin
      rdata = mem_q[addr];
    end
  end

endmodule

// File: rtl/param_data_mem.sv
// Parametrised word-addressed data memory with valid/ready request handshake
// and a one-cycle response pulse after RD_LAT cycles.
// Optional feature: define DMEM_BYTE_WRITE_EN to add req_be byte-lane write enables.
module param_data_mem
  import dmem_pkg::*;
#(
  parameter int unsigned       DATA_W     = 16,
  parameter int unsigned       ADDR_W     = 16,
  parameter int unsigned       DEPTH      = 30,
  parameter int unsigned       RD_LAT     = 1,
  parameter logic [DATA_W-1:0] INIT_WORD0 = 16'hABCD
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
`ifdef DMEM_BYTE_WRITE_EN
  input  logic [DATA_W/8-1:0] req_be,
`endif
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err
);

  localparam int unsigned Lsb = lsb_bits(DATA_W);
  localparam int unsigned NB  = DATA_W / 8;
  localparam int unsigned AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Out-of-range latencies are clamped to the supported range
  localparam int unsigned Lat = (RD_LAT < RdLatMin) ? RdLatMin :
                                (RD_LAT > RdLatMax) ? RdLatMax : RD_LAT;
  localparam int unsigned CntInit = (Lat > 1) ? Lat - 2 : 0;

  dmem_state_e       state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] cap_data_q, cap_data_d;
  logic              cap_err_q, cap_err_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic              accept;
  logic [ADDR_W-1:0] word_idx;
  logic [ADDR_W+31:0] idx_ext;
  logic              misaligned;
  logic              out_of_range;
  logic              acc_err;
  logic [DATA_W-1:0] arr_rdata;
  logic [DATA_W-1:0] acc_data;
  logic              arr_we;
  logic [NB-1:0]     arr_be;

  assign req_ready = (state_q == StIdle);
  assign accept    = req_valid && req_ready;

  // Address decode: flag rather than alias misaligned or out-of-range accesses
  assign word_idx     = req_addr >> Lsb;
  assign idx_ext      = {32'd0, word_idx};
  assign misaligned   = |(req_addr & ADDR_W'((1 << Lsb) - 1));
  assign out_of_range = idx_ext >= (ADDR_W + 32)'(DEPTH);
  assign acc_err      = misaligned || out_of_range;

`ifdef DMEM_BYTE_WRITE_EN
  assign arr_be = req_be;
`else
  assign arr_be = '1;
`endif

  assign arr_we = accept && req_write && !acc_err;

  // Writes and errors report zero data; only a clean read returns the word
  assign acc_data = (!req_write && !acc_err) ? arr_rdata : '0;

  dmem_array #(
    .DATA_W     (DATA_W),
    .DEPTH      (DEPTH),
    .INIT_WORD0 (INIT_WORD0)
  ) u_array (
    .clk   (clk),
    .reset (reset),
    .we    (arr_we),
    .addr  (AW'(word_idx)),
    .wdata (req_wdata),
    .be    (arr_be),
    .rdata (arr_rdata)
  );

  // Next state, wait counter and response capture
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cap_data_d  = cap_data_q;
    cap_err_d   = cap_err_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          cap_data_d = acc_data;
          cap_err_d  = acc_err;
          if (Lat > 1) begin
            state_d = StWait;
            cnt_d   = CntW'(CntInit);
          end else begin
            // Single-cycle latency: the response registers load straight away
            state_d     = StResp;
            rsp_rdata_d = acc_data;
            rsp_err_d   = acc_err;
          end
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          state_d     = StResp;
          rsp_rdata_d = cap_data_q;
          rsp_err_d   = cap_err_q;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and response registers; reset drops any in-flight request
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      cap_data_q  <= '0;
      cap_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cap_data_q  <= cap_data_d;
      cap_err_q   <= cap_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign rsp_valid = (state_q == StResp);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_param_data_mem.sv
// Bench for param_data_mem: one instance at RD_LAT=1 and one at RD_LAT=4, driven
// with directed and random requests and checked against an array-based model.
module tb_param_data_mem;

  localparam int Depth = 30;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Instance with RD_LAT = 1
  logic        v1, w1, rdy1, rv1, re1;
  logic [15:0] a1, d1, rd1;
  logic [1:0]  be1;
  // Instance with RD_LAT = 4
  logic        v4, w4, rdy4, rv4, re4;
  logic [15:0] a4, d4, rd4;
  logic [1:0]  be4;

  param_data_mem #(.RD_LAT(1)) dut1 (
    .clk       (clk),
    .reset     (reset),
    .req_valid (v1),
    .req_ready (rdy1),
    .req_write (w1),
    .req_addr  (a1),
    .req_wdata (d1),
`ifdef DMEM_BYTE_WRITE_EN
    .req_be    (be1),
`endif
    .rsp_valid (rv1),
    .rsp_rdata (rd1),
    .rsp_err   (re1)
  );

  param_data_mem #(.RD_LAT(4)) dut4 (
    .clk       (clk),
    .reset     (reset),
    .req_valid (v4),
    .req_ready (rdy4),
    .req_write (w4),
    .req_addr  (a4),
    .req_wdata (d4),
`ifdef DMEM_BYTE_WRITE_EN
    .req_be    (be4),
`endif
    .rsp_valid (rv4),
    .rsp_rdata (rd4),
    .rsp_err   (re4)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference memories, one per instance
  logic [15:0] m1 [Depth];
  logic [15:0] m4 [Depth];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < Depth; i++) begin
      m1[i] = (i == 0) ? 16'hABCD : 16'h0000;
      m4[i] = (i == 0) ? 16'hABCD : 16'h0000;
    end
  endtask

  // Expected response for one request, updating the model on a good write
  task automatic model_op(input int sel, input logic w, input logic [15:0] a,
                          input logic [15:0] d, input logic [1:0] be,
                          output logic [15:0] exp_d, output logic exp_e);
    int          idx;
    logic [15:0] mask;
    logic [15:0] old;
    idx   = int'(a) / 2;
    exp_e = (a % 2 != 0) || (idx >= Depth);
    exp_d = 16'h0000;
    if (!exp_e) begin
      old = sel ? m4[idx] : m1[idx];
      if (w) begin
        mask = {{8{be[1]}}, {8{be[0]}}};
        if (sel) m4[idx] = (old & ~mask) | (d & mask);
        else     m1[idx] = (old & ~mask) | (d & mask);
      end else begin
        exp_d = old;
      end
    end
  endtask

  task automatic drive(input int sel, input logic v, input logic w, input logic [15:0] a,
                       input logic [15:0] d, input logic [1:0] be);
    if (sel != 0) begin
      v4 = v; w4 = w; a4 = a; d4 = d; be4 = be;
    end else begin
      v1 = v; w1 = w; a1 = a; d1 = d; be1 = be;
    end
  endtask

  function automatic logic get_rdy(input int sel);
    return (sel != 0) ? rdy4 : rdy1;
  endfunction
  function automatic logic get_rv(input int sel);
    return (sel != 0) ? rv4 : rv1;
  endfunction
  function automatic logic [15:0] get_rd(input int sel);
    return (sel != 0) ? rd4 : rd1;
  endfunction
  function automatic logic get_re(input int sel);
    return (sel != 0) ? re4 : re1;
  endfunction

  // One complete request: handshake, latency, busy window, response and hold
  task automatic xact(input int sel, input logic w, input logic [15:0] a,
                      input logic [15:0] d, input logic [1:0] be);
    int          lat;
    int          k;
    logic [15:0] ed;
    logic        ee;
    logic [1:0]  eff_be;
    lat = (sel != 0) ? 4 : 1;
`ifdef DMEM_BYTE_WRITE_EN
    eff_be = be;
`else
    eff_be = 2'b11;
`endif
    @(negedge clk);
    chk("ready_idle", get_rdy(sel), 1'b1);
    drive(sel, 1'b1, w, a, d, be);
    model_op(sel, w, a, d, eff_be, ed, ee);
    @(posedge clk);
    #1;
    // A stray write presented while busy must be ignored
    drive(sel, 1'b1, 1'b1, 16'(2 * $urandom_range(0, Depth - 1)), 16'($urandom), 2'b11);
    k = 0;
    while (!get_rv(sel) && k < 20) begin
      chk("ready_busy", get_rdy(sel), 1'b0);
      @(posedge clk);
      #1;
      k++;
    end
    chk("rsp_latency", k, lat - 1);
    chk("ready_in_rsp", get_rdy(sel), 1'b0);
    chk("rsp_rdata", get_rd(sel), ed);
    chk("rsp_err", get_re(sel), ee);
    @(posedge clk);
    #1;
    drive(sel, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00);
    chk("rsp_pulse_end", get_rv(sel), 1'b0);
    chk("ready_after", get_rdy(sel), 1'b1);
    chk("rdata_hold", get_rd(sel), ed);
    chk("err_hold", get_re(sel), ee);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_rv1", rv1, 1'b0);
    chk("rst_rdy1", rdy1, 1'b1);
    chk("rst_rd1", rd1, 16'h0000);
    chk("rst_re1", re1, 1'b0);
    chk("rst_rv4", rv4, 1'b0);
    chk("rst_rdy4", rdy4, 1'b1);
    chk("rst_rd4", rd4, 16'h0000);
    chk("rst_re4", re4, 1'b0);
  endtask

  int          acc_tq [$];
  logic [15:0] exp_dq [$];

  initial begin
    logic [15:0] b2b_addr [3];
    logic [15:0] ed;
    logic        ee;
    logic        acc;
    int          last_acc;
    int          n_acc;
    int          n_rsp;

    reset = 1'b0;
    drive(0, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00);
    drive(1, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00);
    model_reset();
    #12;
    chk_reset_outputs();
    @(negedge clk);
    reset = 1'b1;

    // Directed: initial word, write/read-back, misaligned and out-of-range
    for (int s = 0; s < 2; s++) begin
      xact(s, 1'b0, 16'h0000, 16'h0000, 2'b11);
      xact(s, 1'b1, 16'h0008, 16'h1234, 2'b11);
      xact(s, 1'b0, 16'h0008, 16'h0000, 2'b11);
      xact(s, 1'b0, 16'h0003, 16'h0000, 2'b11);
      xact(s, 1'b1, 16'h003C, 16'hFFFF, 2'b11);
      xact(s, 1'b0, 16'h003C, 16'h0000, 2'b11);
      xact(s, 1'b0, 16'h003A, 16'h0000, 2'b11);
    end

`ifdef DMEM_BYTE_WRITE_EN
    // Low lane only: word 0 still holds its reset value here
    xact(0, 1'b1, 16'h0000, 16'hBEEF, 2'b01);
    xact(0, 1'b0, 16'h0000, 16'h0000, 2'b11);
    chk("be_readback", rd1, 16'hABEF);
    xact(0, 1'b1, 16'h0002, 16'h5555, 2'b00);
    xact(0, 1'b0, 16'h0002, 16'h0000, 2'b11);
`endif

    // Random traffic, including misaligned and out-of-range addresses
    for (int i = 0; i < 24; i++) begin
      xact(i % 2, 1'($urandom), 16'($urandom_range(0, 16'h3F)), 16'($urandom), 2'($urandom));
    end

    // Back-to-back reads on the RD_LAT=4 instance with req_valid held high
    b2b_addr[0] = 16'h0000;
    b2b_addr[1] = 16'h0008;
    b2b_addr[2] = 16'h0011;
    last_acc = -1;
    n_acc = 0;
    n_rsp = 0;
    @(negedge clk);
    drive(1, 1'b1, 1'b0, b2b_addr[0], 16'h0000, 2'b11);
    for (int t = 0; t < 20; t++) begin
      acc = rdy4 && v4;
      if (acc) begin
        model_op(1, 1'b0, a4, 16'h0000, 2'b11, ed, ee);
        acc_tq.push_back(t);
        exp_dq.push_back(ed);
        if (last_acc >= 0) chk("b2b_period", t - last_acc, 5);
        last_acc = t;
      end
      @(posedge clk);
      #1;
      if (acc) begin
        n_acc++;
        if (n_acc < 3) drive(1, 1'b1, 1'b0, b2b_addr[n_acc], 16'h0000, 2'b11);
        else drive(1, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00);
      end
      if (rv4) begin
        n_rsp++;
        if (acc_tq.size() == 0) begin
          chk("b2b_spurious_rsp", rv4, 1'b0);
        end else begin
          chk("b2b_latency", t - acc_tq.pop_front(), 3);
          chk("b2b_rdata", rd4, exp_dq.pop_front());
        end
      end
      @(negedge clk);
    end
    chk("b2b_rsp_count", n_rsp, 3);

    // Reset while the RD_LAT=4 instance is waiting on a read
    xact(1, 1'b1, 16'h0008, 16'h5A5A, 2'b11);
    @(negedge clk);
    drive(1, 1'b1, 1'b0, 16'h0008, 16'h0000, 2'b11);
    @(posedge clk);
    #1;
    drive(1, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00);
    chk("mid_busy", rdy4, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk_reset_outputs();
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      chk("no_rsp_after_reset", rv4, 1'b0);
    end
    xact(1, 1'b0, 16'h0008, 16'h0000, 2'b11);
    chk("reinit_word4", rd4, 16'h0000);
    xact(1, 1'b0, 16'h0000, 16'h0000, 2'b11);
    xact(0, 1'b0, 16'h0008, 16'h0000, 2'b11);
    xact(0, 1'b0, 16'h0000, 16'h0000, 2'b11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
